// File: rtl/cobra_movimento.sv
// Snake movement engine: applies the filtered direction on each tick, keeps the body in a
// circular position buffer, detects food and self-collision, and serves a segment read port.
module cobra_movimento #(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int XW       = 5,
   parameter int YW       = 5,
   parameter int MAX_LEN  = 64,
   parameter int LW       = 7,
   parameter int INIT_LEN = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic [1:0]    cobra_dir,
   input  logic [XW-1:0] food_x,
   input  logic [YW-1:0] food_y,
   input  logic [LW-1:0] seg_idx,
   output logic [1:0]    cobra_dir_atual,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y,
   output logic [LW-1:0] length,
   output logic          busy,
   output logic          comeu,
   output logic          game_over,
   output logic [XW-1:0] seg_x,
   output logic [YW-1:0] seg_y
);

   localparam int unsigned AW = $clog2(MAX_LEN);
   localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2,
      DEAD   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [XW-1:0] mem_x [MAX_LEN];
   logic [YW-1:0] mem_y [MAX_LEN];
   logic [AW-1:0] hp_q;
   logic [LW-1:0] j_q;
   logic [XW-1:0] nh_x_q;
   logic [YW-1:0] nh_y_q;
   logic [1:0]    d_q;
   logic          eat_q;
   logic          hit_q;

   logic          start_c;
   logic [1:0]    dir_c;
   logic [XW-1:0] nx_c;
   logic [YW-1:0] ny_c;
   logic [LW-1:0] last_idx_c;
   logic [AW-1:0] scan_ptr_c;
   logic [AW-1:0] rd_ptr_c;
   logic          scan_match_c;

   // Reject a direct reversal: opposite codes differ only in bit 0.
   always_comb begin
      dir_c = cobra_dir;
      if ((cobra_dir ^ cobra_dir_atual) == 2'b01) dir_c = cobra_dir_atual;
   end

   // Candidate head with toroidal wrap.
   always_comb begin
      nx_c = head_x;
      ny_c = head_y;
      case (dir_c)
         2'b00:   ny_c = (head_y == '0)    ? Y_MAX : head_y - YW'(1);
         2'b01:   ny_c = (head_y == Y_MAX) ? '0    : head_y + YW'(1);
         2'b10:   nx_c = (head_x == '0)    ? X_MAX : head_x - XW'(1);
         default: nx_c = (head_x == X_MAX) ? '0    : head_x + XW'(1);
      endcase
   end

   // The tail cell is only checked when growing, since otherwise it vacates this move.
   always_comb begin
      last_idx_c   = eat_q ? (length - LW'(1)) : (length - LW'(2));
      scan_ptr_c   = hp_q - AW'(j_q);
      scan_match_c = (mem_x[scan_ptr_c] == nh_x_q) && (mem_y[scan_ptr_c] == nh_y_q);
      rd_ptr_c     = hp_q - AW'(seg_idx);
   end

   always_comb begin
      state_d = state_q;
      start_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && !game_over) begin
               start_c = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (j_q == last_idx_c) state_d = COMMIT;
         end
         COMMIT: begin
            state_d = hit_q ? DEAD : IDLE;
         end
         default: state_d = DEAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < MAX_LEN; k++) begin
            if (k < INIT_LEN) begin
               mem_x[AW'(k)] <= XW'(GRID_W / 2 - (INIT_LEN - 1 - k));
               mem_y[AW'(k)] <= YW'(GRID_H / 2);
            end else begin
               mem_x[AW'(k)] <= '0;
               mem_y[AW'(k)] <= '0;
            end
         end
         hp_q            <= AW'(INIT_LEN - 1);
         j_q             <= '0;
         nh_x_q          <= '0;
         nh_y_q          <= '0;
         d_q             <= 2'b11;
         eat_q           <= 1'b0;
         hit_q           <= 1'b0;
         head_x          <= XW'(GRID_W / 2);
         head_y          <= YW'(GRID_H / 2);
         length          <= LW'(INIT_LEN);
         cobra_dir_atual <= 2'b11;
         busy            <= 1'b0;
         comeu           <= 1'b0;
         game_over       <= 1'b0;
         seg_x           <= '0;
         seg_y           <= '0;
      end else begin
         comeu <= 1'b0;

         // Read port sees pre-move contents; the buffer only changes at COMMIT.
         if (seg_idx >= length) begin
            seg_x <= '0;
            seg_y <= '0;
         end else begin
            seg_x <= mem_x[rd_ptr_c];
            seg_y <= mem_y[rd_ptr_c];
         end

         case (state_q)
            IDLE: begin
               if (start_c) begin
                  d_q    <= dir_c;
                  nh_x_q <= nx_c;
                  nh_y_q <= ny_c;
                  eat_q  <= (nx_c == food_x) && (ny_c == food_y);
                  hit_q  <= 1'b0;
                  j_q    <= '0;
                  busy   <= 1'b1;
               end
            end
            SCAN: begin
               if (scan_match_c) hit_q <= 1'b1;
               j_q <= j_q + LW'(1);
            end
            COMMIT: begin
               busy <= 1'b0;
               if (hit_q) begin
                  game_over <= 1'b1;
               end else begin
                  // At full length the new head overwrites the oldest slot, dropping the tail.
                  hp_q                  <= hp_q + AW'(1);
                  mem_x[hp_q + AW'(1)]  <= nh_x_q;
                  mem_y[hp_q + AW'(1)]  <= nh_y_q;
                  head_x                <= nh_x_q;
                  head_y                <= nh_y_q;
                  cobra_dir_atual       <= d_q;
                  if (eat_q) begin
                     comeu <= 1'b1;
                     if (length < LW'(MAX_LEN)) length <= length + LW'(1);
                  end
               end
            end
            default: begin
               game_over <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cobra_movimento.sv
// Directed bench for cobra_movimento: movement, reversal filter, wrap, eating, tail
// boundary collision and mid-move reset, with hand-computed expectations.
module tb_cobra_movimento;

   logic       clk;
   logic       reset;
   logic       tick;
   logic [1:0] cobra_dir;
   logic [4:0] food_x;
   logic [4:0] food_y;
   logic [6:0] seg_idx;
   logic [1:0] cobra_dir_atual;
   logic [4:0] head_x;
   logic [4:0] head_y;
   logic [6:0] length;
   logic       busy;
   logic       comeu;
   logic       game_over;
   logic [4:0] seg_x;
   logic [4:0] seg_y;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   cobra_movimento dut (
      .clk             (clk),
      .reset           (reset),
      .tick            (tick),
      .cobra_dir       (cobra_dir),
      .food_x          (food_x),
      .food_y          (food_y),
      .seg_idx         (seg_idx),
      .cobra_dir_atual (cobra_dir_atual),
      .head_x          (head_x),
      .head_y          (head_y),
      .length          (length),
      .busy            (busy),
      .comeu           (comeu),
      .game_over       (game_over),
      .seg_x           (seg_x),
      .seg_y           (seg_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset;
      reset = 1'b1;
      tick  = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Issue one tick; report busy-high cycles and comeu-high samples seen around the move.
   task automatic do_tick(input logic [1:0] dir, output int bcyc, output int ccnt);
      cobra_dir = dir;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      bcyc = 0;
      ccnt = 0;
      while (busy && bcyc < 200) begin
         bcyc++;
         if (comeu) ccnt++;
         @(posedge clk); #1;
      end
      if (busy) begin
         chk_cnt++;
         $display("FAIL tick_timeout busy still high after %0d cycles", bcyc);
      end
      if (comeu) ccnt++;
      @(posedge clk); #1;
      if (comeu) ccnt++;
   endtask

   task automatic read_seg(input int idx, output logic [4:0] x, output logic [4:0] y);
      seg_idx = 7'(idx);
      @(posedge clk); #1;
      x = seg_x;
      y = seg_y;
   endtask

   task automatic test_reset;
      logic [4:0] x, y;
      do_reset();
      chk_cnt++;
      if ({head_x, head_y, length, cobra_dir_atual, game_over, busy, comeu} !==
          {5'd16, 5'd12, 7'd3, 2'b11, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL reset_state got head=(%0d,%0d) len=%0d dir=%b go=%b busy=%b comeu=%b want (16,12) 3 11 0 0 0",
                  head_x, head_y, length, cobra_dir_atual, game_over, busy, comeu);
      end else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         read_seg(i, x, y);
         chk_cnt++;
         if ({x, y} !== {5'(16 - i), 5'd12}) begin
            $display("FAIL reset_seg%0d got (%0d,%0d) want (%0d,12)", i, x, y, 16 - i);
         end else pass_cnt++;
      end
      read_seg(3, x, y);
      chk_cnt++;
      if ({x, y} !== 10'd0) begin
         $display("FAIL seg_out_of_range got (%0d,%0d) want (0,0)", x, y);
      end else pass_cnt++;
   endtask

   task automatic test_move;
      int bc, cc;
      logic [4:0] x, y;
      do_reset();
      food_x = 5'd0; food_y = 5'd0;
      do_tick(2'b11, bc, cc);
      chk_cnt++;
      if (bc !== 3) $display("FAIL move_busy got %0d cycles want 3", bc);
      else pass_cnt++;
      chk_cnt++;
      if ({head_x, head_y, length, cc} !== {5'd17, 5'd12, 7'd3, 32'd0}) begin
         $display("FAIL move_head got (%0d,%0d) len=%0d comeu_samples=%0d want (17,12) 3 0",
                  head_x, head_y, length, cc);
      end else pass_cnt++;
      read_seg(2, x, y);
      chk_cnt++;
      if ({x, y} !== {5'd15, 5'd12}) $display("FAIL move_seg2 got (%0d,%0d) want (15,12)", x, y);
      else pass_cnt++;
   endtask

   task automatic test_reversal_wrap;
      int bc, cc;
      logic [4:0] x, y;
      do_tick(2'b10, bc, cc);
      chk_cnt++;
      if ({head_x, head_y, cobra_dir_atual} !== {5'd18, 5'd12, 2'b11}) begin
         $display("FAIL reversal got (%0d,%0d) dir=%b want (18,12) 11", head_x, head_y, cobra_dir_atual);
      end else pass_cnt++;
      do_reset();
      for (int i = 0; i < 15; i++) do_tick(2'b11, bc, cc);
      chk_cnt++;
      if ({head_x, head_y} !== {5'd31, 5'd12}) $display("FAIL wrap_edge got (%0d,%0d) want (31,12)", head_x, head_y);
      else pass_cnt++;
      do_tick(2'b11, bc, cc);
      chk_cnt++;
      if ({head_x, head_y} !== {5'd0, 5'd12}) $display("FAIL wrap_x got (%0d,%0d) want (0,12)", head_x, head_y);
      else pass_cnt++;
      read_seg(1, x, y);
      chk_cnt++;
      if ({x, y} !== {5'd31, 5'd12}) $display("FAIL wrap_seg1 got (%0d,%0d) want (31,12)", x, y);
      else pass_cnt++;
      do_tick(2'b00, bc, cc);
      chk_cnt++;
      if ({head_x, head_y, cobra_dir_atual} !== {5'd0, 5'd11, 2'b00}) begin
         $display("FAIL move_up got (%0d,%0d) dir=%b want (0,11) 00", head_x, head_y, cobra_dir_atual);
      end else pass_cnt++;
   endtask

   task automatic test_eat;
      int bc, cc;
      logic [4:0] x, y;
      do_reset();
      food_x = 5'd17; food_y = 5'd12;
      do_tick(2'b11, bc, cc);
      chk_cnt++;
      if (bc !== 4) $display("FAIL eat_busy got %0d cycles want 4", bc);
      else pass_cnt++;
      chk_cnt++;
      if (cc !== 1) $display("FAIL eat_pulse got %0d comeu samples want 1", cc);
      else pass_cnt++;
      chk_cnt++;
      if ({head_x, head_y, length} !== {5'd17, 5'd12, 7'd4}) begin
         $display("FAIL eat_len got (%0d,%0d) len=%0d want (17,12) 4", head_x, head_y, length);
      end else pass_cnt++;
      read_seg(3, x, y);
      chk_cnt++;
      if ({x, y} !== {5'd14, 5'd12}) $display("FAIL eat_tail got (%0d,%0d) want (14,12)", x, y);
      else pass_cnt++;
   endtask

   task automatic test_tail_boundary;
      int bc, cc;
      // Length 4, continuing from test_eat: head walks into the vacating tail cell.
      food_x = 5'd0; food_y = 5'd0;
      do_tick(2'b00, bc, cc);
      do_tick(2'b10, bc, cc);
      do_tick(2'b01, bc, cc);
      chk_cnt++;
      if ({head_x, head_y, game_over, length, bc} !== {5'd16, 5'd12, 1'b0, 7'd4, 32'd4}) begin
         $display("FAIL tail_len4 got (%0d,%0d) go=%b len=%0d busy=%0d want (16,12) 0 4 4",
                  head_x, head_y, game_over, length, bc);
      end else pass_cnt++;
      // Length 5: the same cell is now a live body segment.
      do_reset();
      food_x = 5'd17; food_y = 5'd12;
      do_tick(2'b11, bc, cc);
      food_x = 5'd18;
      do_tick(2'b11, bc, cc);
      food_x = 5'd0; food_y = 5'd0;
      do_tick(2'b00, bc, cc);
      do_tick(2'b10, bc, cc);
      do_tick(2'b01, bc, cc);
      chk_cnt++;
      if ({game_over, head_x, head_y, length, cobra_dir_atual, bc} !==
          {1'b1, 5'd17, 5'd11, 7'd5, 2'b10, 32'd5}) begin
         $display("FAIL tail_len5 got go=%b (%0d,%0d) len=%0d dir=%b busy=%0d want 1 (17,11) 5 10 5",
                  game_over, head_x, head_y, length, cobra_dir_atual, bc);
      end else pass_cnt++;
      cobra_dir = 2'b10;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++;
      if ({busy, game_over, head_x, head_y} !== {1'b0, 1'b1, 5'd17, 5'd11}) begin
         $display("FAIL dead_ignore got busy=%b go=%b (%0d,%0d) want 0 1 (17,11)",
                  busy, game_over, head_x, head_y);
      end else pass_cnt++;
      do_reset();
      chk_cnt++;
      if ({game_over, head_x, head_y, length} !== {1'b0, 5'd16, 5'd12, 7'd3}) begin
         $display("FAIL dead_reset got go=%b (%0d,%0d) len=%0d want 0 (16,12) 3",
                  game_over, head_x, head_y, length);
      end else pass_cnt++;
   endtask

   task automatic test_reset_mid_scan;
      int cc;
      logic [4:0] x, y;
      do_reset();
      food_x = 5'd17; food_y = 5'd12;
      cobra_dir = 2'b00;
      tick = 1'b1;
      @(posedge clk); #1;
      tick  = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_cnt++;
      if ({busy, comeu, head_x, head_y, length, cobra_dir_atual, game_over} !==
          {1'b0, 1'b0, 5'd16, 5'd12, 7'd3, 2'b11, 1'b0}) begin
         $display("FAIL midscan_reset got busy=%b comeu=%b (%0d,%0d) len=%0d dir=%b go=%b want 0 0 (16,12) 3 11 0",
                  busy, comeu, head_x, head_y, length, cobra_dir_atual, game_over);
      end else pass_cnt++;
      cc = 0;
      for (int i = 0; i < 4; i++) begin
         read_seg(i, x, y);
         if (comeu || busy) cc++;
      end
      chk_cnt++;
      if (cc !== 0) $display("FAIL midscan_quiet got %0d active samples want 0", cc);
      else pass_cnt++;
      read_seg(1, x, y);
      chk_cnt++;
      if ({x, y} !== {5'd15, 5'd12}) $display("FAIL midscan_seg1 got (%0d,%0d) want (15,12)", x, y);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; cobra_dir = 2'b11;
      food_x = 5'd0; food_y = 5'd0; seg_idx = 7'd0;
      @(posedge clk); #1;
      test_reset();
      test_move();
      test_reversal_wrap();
      test_eat();
      test_tail_boundary();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/cobra_movimento.md
Name: cobra_movimento

Overview:
Snake movement engine. It consumes the filtered direction code (cobra_dir) from the button-to-direction block and feeds back the direction actually applied (cobra_dir_atual), closing the loop that block uses for reversal filtering. On each game tick it advances the head one cell on a wrapping grid and keeps the body in a circular position buffer. It also detects food and self-collision, and exposes a segment read port for the VGA renderer.

Parameters:
GRID_W, 32, grid columns (x range 0..GRID_W-1)
GRID_H, 24, grid rows (y range 0..GRID_H-1, y=0 is top)
XW, 5, x coordinate width
YW, 5, y coordinate width
MAX_LEN, 64, body buffer depth; power of 2
LW, 7, length/index width (holds MAX_LEN)
INIT_LEN, 3, length after reset (2..MAX_LEN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle move request; ignored unless IDLE and not game_over
cobra_dir  input  2  requested direction: 00 up, 01 down, 10 left, 11 right
food_x  input  XW  food column
food_y  input  YW  food row
seg_idx  input  LW  segment index for read port (0 = head)
cobra_dir_atual  output  2  direction of last committed move
head_x  output  XW  head column
head_y  output  YW  head row
length  output  LW  current segment count
busy  output  1  move in progress
comeu  output  1  one-cycle pulse: food eaten on committed move
game_over  output  1  self-collision occurred; sticky
seg_x  output  XW  column of segment seg_idx, registered
seg_y  output  YW  row of segment seg_idx, registered

Behaviour:
- Reset (sync, active-high; wins over everything, aborts any move):
  - cx=GRID_W/2, cy=GRID_H/2.
  - Segment i at (cx-i, cy) for i=0..INIT_LEN-1.
  - length=INIT_LEN, cobra_dir_atual=11, busy=0, comeu=0, game_over=0, seg_x/seg_y=0, state IDLE.
- Buffer: circular, head pointer hp. Segment i is stored at mem[(hp-i) mod MAX_LEN].
- States: IDLE, SCAN, COMMIT, DEAD.
- IDLE, on tick (not game_over):
  - Direction d = cobra_dir, unless it is the opposite of cobra_dir_atual (00<->01, 10<->11); then d = cobra_dir_atual.
  - Compute new head nh: up y-1, down y+1, left x-1, right x+1.
  - Wrap: x=GRID_W-1 +1 -> 0; x=0 -1 -> GRID_W-1; same rule for y with GRID_H.
  - eat = (nh == food). Latch d, nh and eat.
  - busy=1. Go to SCAN with j=0.
- SCAN: compares nh with old segment j, one per cycle.
  - Last index checked is L-2 if not eat, L-1 if eat. The tail vacates unless growing.
  - Any match sets hit.
  - After the last index, go to COMMIT.
- COMMIT:
  - If hit: game_over=1, head/body/length/cobra_dir_atual unchanged, go to DEAD.
  - Else: hp+1, write nh, cobra_dir_atual=d.
  - Else, if eat: comeu=1 for exactly one cycle; length+1 if length<MAX_LEN, otherwise length saturates and the tail is dropped.
  - busy=0 and return to IDLE, visible the edge after COMMIT.
- Latency: busy is high for exactly N+1 cycles, where N = number of segments scanned (L-1 or L). Outputs update together.
- tick while busy or in DEAD: ignored, not queued.
- DEAD: holds until reset. game_over=1, busy=0.
- Read port:
  - seg_x/seg_y show segment seg_idx one cycle after seg_idx is presented.
  - seg_idx >= length gives (0,0).
  - During busy, the read port shows pre-move contents; the write occurs at COMMIT.

Test Plan:
1. Reset -> head (16,12), length 3, seg1 (15,12), seg2 (14,12), cobra_dir_atual 11, game_over 0, busy 0.
2. tick, cobra_dir=11, food (0,0) -> busy 3 cycles; head (17,12); seg2 reads (15,12); comeu stays 0.
3. Reversal: cobra_dir=10 while cobra_dir_atual=11, tick -> head (18,12), cobra_dir_atual 11. Wrap case: head x=31 moving right, tick -> head x=0.
4. food (17,12) after reset, tick right -> comeu one-cycle pulse, length 4, busy 4 cycles, tail still (14,12).
5. Tail boundary:
   - Length 4, directions up, left, down -> head enters old tail cell; no collision, game_over 0.
   - Same sequence at length 5 -> game_over 1 at COMMIT, head/length unchanged; later ticks ignored; reset clears.
6. Reset asserted mid-SCAN -> next cycle equals scenario-1 state, busy 0, no comeu pulse.
